// File: rtl/multibyte_add_seq.sv
// Sequential multi-byte adder/subtractor that drives an external 8-bit byte adder,
// processing one byte per clock from least to most significant.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_c,
  input  logic [7:0]            add_sum,
  input  logic                  add_co,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   O,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    areg;
  logic [W-1:0]    breg;
  logic            carry;
  logic            last;
  logic            accept;

  assign last   = (idx == IW'(NBYTES - 1));
  assign accept = start && (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ovf uses the byte being written on the final edge, since O's MSB is not yet registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      O     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      areg  <= A;
      breg  <= sub ? ~B : B;
      carry <= sub;
      idx   <= '0;
      O     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      O[{idx, 3'b000} +: 8] <= add_sum;
      carry                 <= add_co;
      if (last) begin
        cout <= add_co;
        ovf  <= (areg[W-1] == breg[W-1]) && (add_sum[7] != areg[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    if (state == RUN) begin
      add_a = areg[{idx, 3'b000} +: 8];
      add_b = breg[{idx, 3'b000} +: 8];
      add_c = carry;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
